// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between the fetch stage and its neighbours
// (hazard unit, execute stage, instruction memory, decode).
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output update_valid, update_pc, update_taken, update_target,
    input  imem_addr,
    output imem_dout,
    input  if_id_valid, if_id_pc, if_id_inst, if_id_pred_taken, if_id_pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  update_valid, update_pc, update_taken, update_target,
    output imem_addr,
    input  imem_dout,
    output if_id_valid, if_id_pc, if_id_inst, if_id_pred_taken, if_id_pred_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, direct-mapped BTB with 2-bit counters,
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter int          BTB_ENTRIES = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave bus
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [31:0]   pc_r;
  logic          btb_valid_r  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag_r    [BTB_ENTRIES];
  logic [31:0]   btb_target_r [BTB_ENTRIES];
  logic [1:0]    btb_ctr_r    [BTB_ENTRIES];

  logic          if_id_valid_r;
  logic [31:0]   if_id_pc_r;
  logic [31:0]   if_id_inst_r;
  logic          if_id_pred_taken_r;
  logic [31:0]   if_id_pred_target_r;

  logic [IDX-1:0] lk_idx_s;
  logic [IDX-1:0] up_idx_s;
  logic           lk_hit_s;
  logic           up_hit_s;
  logic           pred_taken_s;
  logic [31:0]    pred_next_s;
  logic [31:0]    next_pc_s;

  // BTB lookup on the current pc and hit detection for the training port
  always_comb begin
    lk_idx_s     = pc_r[IDX+1:2];
    lk_hit_s     = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == pc_r[31:IDX+2]);
    pred_taken_s = lk_hit_s && btb_ctr_r[lk_idx_s][1];
    if (pred_taken_s) begin
      pred_next_s = btb_target_r[lk_idx_s];
    end else begin
      pred_next_s = pc_r + 32'd4;
    end
    up_idx_s = bus.update_pc[IDX+1:2];
    up_hit_s = btb_valid_r[up_idx_s] && (btb_tag_r[up_idx_s] == bus.update_pc[31:IDX+2]);
  end

  // Next-PC selection; redirect deliberately outranks stall
  always_comb begin
    next_pc_s = pred_next_s;
    if (reset) begin
      next_pc_s = RESET_PC;
    end else if (bus.redirect_valid) begin
      next_pc_s = bus.redirect_pc;
    end else if (bus.stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pred_next_s;
    end
  end

  // PC register and IF/ID pipeline register
  always_ff @(posedge clk) begin
    pc_r <= next_pc_s;
    if (reset) begin
      if_id_valid_r       <= 1'b0;
      if_id_pc_r          <= 32'h0000_0000;
      if_id_inst_r        <= 32'h0000_0000;
      if_id_pred_taken_r  <= 1'b0;
      if_id_pred_target_r <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      if_id_valid_r <= 1'b0;
      if_id_inst_r  <= 32'h0000_0000;
    end else if (bus.stall) begin
      if_id_valid_r <= if_id_valid_r;
    end else begin
      if_id_valid_r       <= 1'b1;
      if_id_pc_r          <= pc_r;
      if_id_inst_r        <= bus.imem_dout;
      if_id_pred_taken_r  <= pred_taken_s;
      if_id_pred_target_r <= pred_next_s;
    end
  end

  // BTB training; lookups in the same cycle still see the old entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_r[i] <= 1'b0;
        btb_ctr_r[i]   <= 2'b01;
      end
    end else if (bus.update_valid) begin
      if (up_hit_s) begin
        if (bus.update_taken) begin
          btb_target_r[up_idx_s] <= bus.update_target;
          if (btb_ctr_r[up_idx_s] != 2'b11) begin
            btb_ctr_r[up_idx_s] <= btb_ctr_r[up_idx_s] + 2'b01;
          end
        end else if (btb_ctr_r[up_idx_s] != 2'b00) begin
          btb_ctr_r[up_idx_s] <= btb_ctr_r[up_idx_s] - 2'b01;
        end else begin
          btb_ctr_r[up_idx_s] <= 2'b00;
        end
      end else if (bus.update_taken) begin
        btb_valid_r[up_idx_s]  <= 1'b1;
        btb_tag_r[up_idx_s]    <= bus.update_pc[31:IDX+2];
        btb_target_r[up_idx_s] <= bus.update_target;
        btb_ctr_r[up_idx_s]    <= 2'b10;
      end else begin
        btb_valid_r[up_idx_s] <= btb_valid_r[up_idx_s];
      end
    end else begin
      btb_valid_r[0] <= btb_valid_r[0];
    end
  end

  assign bus.imem_addr         = pc_r;
  assign bus.if_id_valid       = if_id_valid_r;
  assign bus.if_id_pc          = if_id_pc_r;
  assign bus.if_id_inst        = if_id_inst_r;
  assign bus.if_id_pred_taken  = if_id_pred_taken_r;
  assign bus.if_id_pred_target = if_id_pred_target_r;
endmodule
